// File: rtl/fifo_packetizer.sv
// rtl/fifo_packetizer.sv - frames fixed-length fifo payloads as SYNC, SEQ, data, XOR checksum
// Single-entry registered output stage with valid/ready towards the TX side.
module fifo_packetizer #(
  parameter int                   DATASIZE    = 8,
  parameter int                   PAYLOAD_LEN = 16,
  parameter logic [DATASIZE-1:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  output logic [DATASIZE-1:0] odata,
  output logic                ovalid,
  input  logic                oready,
  output logic                osof,
  output logic                oeof
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_SEQ     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  logic [2:0]          state;
  logic [7:0]          seq;
  logic [DATASIZE-1:0] chk;
  logic [CW-1:0]       count;
  logic                load_en;

  assign load_en = !ovalid || oready;

  // Pops only when the output stage can take the byte, so a pop always lands in odata.
  always_comb begin
    rinc = rrst_n && (state == S_PAYLOAD) && load_en && !rempty;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state  <= S_IDLE;
      seq    <= '0;
      chk    <= '0;
      count  <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
      osof   <= 1'b0;
      oeof   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en) ovalid <= 1'b0;
          if (!rempty) state <= S_SYNC;
        end
        S_SYNC: begin
          if (load_en) begin
            odata  <= SYNC_BYTE;
            osof   <= 1'b1;
            oeof   <= 1'b0;
            ovalid <= 1'b1;
            chk    <= '0;
            state  <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (load_en) begin
            odata  <= DATASIZE'(seq);
            osof   <= 1'b0;
            oeof   <= 1'b0;
            ovalid <= 1'b1;
            state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (rinc) begin
            odata  <= rdata;
            osof   <= 1'b0;
            oeof   <= 1'b0;
            ovalid <= 1'b1;
            chk    <= chk ^ rdata;
            if (count == CW'(PAYLOAD_LEN - 1)) begin
              count <= '0;
              state <= S_CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end else if (load_en) begin
            // Fifo ran dry mid-frame: let the held byte go and wait, never abort.
            ovalid <= 1'b0;
          end
        end
        S_CHECK: begin
          if (load_en) begin
            odata  <= chk;
            osof   <= 1'b0;
            oeof   <= 1'b1;
            ovalid <= 1'b1;
            seq    <= seq + 8'd1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_packetizer.sv
// tb/tb_fifo_packetizer.sv - scoreboard bench for fifo_packetizer
// A queue models the FWFT fifo; expected frames are queued as payloads are pushed.
module tb_fifo_packetizer;

  localparam int LEN = 16;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       rempty = 1'b1;
  logic       rinc;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready = 1'b1;
  logic       osof;
  logic       oeof;

  fifo_packetizer #(.DATASIZE(8), .PAYLOAD_LEN(LEN), .SYNC_BYTE(8'hA5)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .odata(odata), .ovalid(ovalid), .oready(oready), .osof(osof), .oeof(oeof)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] exp_seq = 8'h00;
  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;
  int n_pushed = 0;
  int mid_gaps = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int lat = -1;
  int idle_bad = 0;
  logic pop_q = 1'b0;
  logic lat_arm = 1'b0;
  logic prev_empty = 1'b1;
  logic in_frame = 1'b0;
  logic hold_v = 1'b0;
  logic [9:0] hold_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fifo model and output monitor; inputs settle at negedge, sampled 1ns later.
  always @(negedge rclk) begin
    if (pop_q && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    rempty = (fifo_q.size() == 0);
    rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    #1;
    cyc++;
    if (prev_empty && !rempty) begin
      fall_cyc = cyc;
      lat_arm  = 1'b1;
    end
    prev_empty = rempty;
    if (lat_arm && ovalid && osof) begin
      lat     = cyc - fall_cyc;
      lat_arm = 1'b0;
    end
    if (rinc) check("rinc_while_empty", {31'd0, rempty}, 32'd0);
    if (rrst_n && hold_v) begin
      check("hold_stable", {22'd0, osof, oeof, odata}, {22'd0, hold_d});
      check("hold_valid", {31'd0, ovalid}, 32'd1);
    end
    if (ovalid && !oready) check("no_pop_on_hold", {31'd0, rinc}, 32'd0);
    hold_v = ovalid && !oready;
    hold_d = {osof, oeof, odata};
    if (!rrst_n) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame && !ovalid) mid_gaps++;
      if (ovalid && oready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {22'd0, osof, oeof, odata}, 32'h3ff);
        else check("frame_byte", {22'd0, osof, oeof, odata}, {22'd0, exp_q.pop_front()});
        if (osof) in_frame = 1'b1;
        if (oeof) in_frame = 1'b0;
      end
    end
    pop_q = rinc;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  // Queues the full expected frame, then feeds split bytes, waits gap cycles, feeds the rest.
  task automatic send_frame(input logic [7:0] base, input int split, input int gap);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.push_back({2'b10, 8'hA5});
    exp_q.push_back({2'b00, exp_seq});
    for (int i = 0; i < LEN; i++) begin
      b = base + 8'(i);
      c = c ^ b;
      exp_q.push_back({2'b00, b});
    end
    exp_q.push_back({2'b01, c});
    exp_seq = exp_seq + 8'd1;
    for (int i = 0; i < split; i++) fifo_q.push_back(base + 8'(i));
    n_pushed += split;
    if (split < LEN) begin
      tick(gap);
      for (int i = split; i < LEN; i++) fifo_q.push_back(base + 8'(i));
      n_pushed += LEN - split;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick(1);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick(4);
  endtask

  initial begin
    rrst_n = 1'b0;
    oready = 1'b1;
    tick(3);
    check("rst_odata", {24'd0, odata}, 32'd0);
    check("rst_flags", {28'd0, ovalid, osof, oeof, rinc}, 32'd0);
    rrst_n = 1'b1;

    repeat (50) begin
      @(negedge rclk);
      #2;
      if (ovalid || rinc || osof || oeof) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);

    n_pops = 0; n_pushed = 0; mid_gaps = 0;
    send_frame(8'h00, LEN, 0);
    wait_drain();
    check("sof_latency", lat, 2);
    check("pops_frame1", n_pops, LEN);
    check("gapless_frame1", mid_gaps, 0);

    n_pops = 0; n_pushed = 0; mid_gaps = 0;
    send_frame(8'h01, LEN, 0);
    send_frame(8'h11, LEN, 0);
    wait_drain();
    check("pops_two_frames", n_pops, n_pushed);
    check("gapless_two_frames", mid_gaps, 0);

    n_pops = 0; n_pushed = 0;
    send_frame(8'h40, LEN, 0);
    tick(8);
    oready = 1'b0;
    tick(5);
    oready = 1'b1;
    wait_drain();
    check("pops_backpressure", n_pops, n_pushed);

    n_pops = 0; n_pushed = 0; mid_gaps = 0;
    send_frame(8'h60, 8, 20);
    wait_drain();
    check("stall_ovalid_drop", {31'd0, mid_gaps > 0}, 32'd1);
    check("pops_stall", n_pops, n_pushed);

    send_frame(8'h80, LEN, 0);
    tick(8);
    rrst_n = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    exp_seq = 8'h00;
    tick(1);
    rrst_n = 1'b1;
    check("midrst_odata", {24'd0, odata}, 32'd0);
    check("midrst_flags", {28'd0, ovalid, osof, oeof, rinc}, 32'd0);
    tick(3);
    n_pops = 0; n_pushed = 0;
    send_frame(8'hC0, LEN, 0);
    wait_drain();
    check("pops_after_rst", n_pops, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
